// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types for the round-robin APB arbiter: FSM states, command encoding
// and the command-validity helper.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } apb_cmd_e;

  // Encoding 2'b11 is reserved and behaves exactly like a NOP.
  function automatic logic cmd_valid(logic [1:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Bundles the requester-side command/response signals and the APB bus that the
// arbiter masters.
interface apb_rr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0][1:0]        req_cmd_i;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ-1:0]             rsp_valid_o;
  logic [DATA_W-1:0]              rsp_rdata_o;
  logic                           psel_o;
  logic                           penable_o;
  logic                           pwrite_o;
  logic [ADDR_W-1:0]              paddr_o;
  logic [DATA_W-1:0]              pwdata_o;
  logic [DATA_W-1:0]              prdata_i;
  logic                           pready_i;

  modport master (
    input  req_cmd_i, req_addr_i, req_wdata_i, prdata_i, pready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );

  modport slave (
    output req_cmd_i, req_addr_i, req_wdata_i, prdata_i, pready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
  );
endinterface

// File: rtl/apb_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i,
// wrapping, found by a priority search over the doubled request vector.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PtrW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PtrW-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PtrW-1:0]    idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] masked;

  always_comb begin
    dbl    = {req_i, req_i};
    masked = '0;
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    // The upper copy supplies the wrapped-around requesters below the pointer.
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      masked[i] = dbl[i] && (i >= int'(rr_ptr_i));
    end
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (masked[i] && !any_o) begin
        any_o = 1'b1;
        idx_o = PtrW'(i % NUM_REQ);
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB bus among NUM_REQ command sources; it
// sequences SETUP/ACCESS itself and routes each completion back to its issuer.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input logic              clk,
  input logic              reset,
  apb_rr_arbiter_if.master bus
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  apb_state_e         state_q, state_d;
  logic [PtrW-1:0]    rr_ptr_q;
  logic [PtrW-1:0]    owner_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic               pwrite_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;

  logic [NUM_REQ-1:0] req_vld;
  logic [NUM_REQ-1:0] gnt;
  logic [PtrW-1:0]    win_idx;
  logic               any_req;
  logic [1:0]         win_cmd;
  logic [NUM_REQ-1:0] owner_oh;
  logic               done;
  logic               accept;

  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vld[i] = cmd_valid(bus.req_cmd_i[i]);
    end
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PtrW   (PtrW)
  ) u_pick (
    .req_i   (req_vld),
    .rr_ptr_i(rr_ptr_q),
    .gnt_o   (gnt),
    .idx_o   (win_idx),
    .any_o   (any_req)
  );

  assign win_cmd = bus.req_cmd_i[win_idx];
  assign done    = (state_q == ACCESS) && bus.pready_i;
  // Gating with reset keeps ready low while the async reset is asserted.
  assign accept  = reset && ((state_q == IDLE) || done) && any_req;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (bus.pready_i) state_d = accept ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else if (accept) begin
      rr_ptr_q <= (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      owner_q  <= win_idx;
      paddr_q  <= bus.req_addr_i[win_idx];
      pwrite_q <= (win_cmd == CMD_WRITE);
      pwdata_q <= (win_cmd == CMD_WRITE) ? bus.req_wdata_i[win_idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= done ? owner_oh : '0;
      rsp_rdata_q <= (done && !pwrite_q) ? bus.prdata_i : '0;
    end
  end

  assign bus.req_ready_o = accept ? gnt : '0;
  assign bus.psel_o      = (state_q != IDLE);
  assign bus.penable_o   = (state_q == ACCESS);
  assign bus.pwrite_o    = pwrite_q;
  assign bus.paddr_o     = paddr_q;
  assign bus.pwdata_o    = pwdata_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed + random bench for apb_rr_arbiter: per-requester command queues feed
// the arbiter, an APB slave model answers, and a scoreboard checks each response.
module tb_apb_rr_arbiter;
  import apb_arb_pkg::*;

  localparam int unsigned N = 4;

  typedef struct {
    int          req;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          req;
    logic [31:0] rdata;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  apb_rr_arbiter_if #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32)) bus ();

  apb_rr_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  cmd_t   pend_q[$];
  exp_t   exp_q[$];
  int     grant_log[$];
  int     grant_cyc[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     wait_cfg = 0;
  bit     rand_wait = 1'b0;
  int     acc_cnt = 0;
  int     cur_wait = 0;
  int     rsp_cnt = 0;
  int     ready1_cnt = 0;
  int     psel_cnt = 0;
  logic [N-1:0] acc_s = '0;

  // Slave read data is a fixed function of the address (0x10 -> 0xA5).
  function automatic logic [31:0] slv_rdata(logic [31:0] a);
    return a ^ 32'h0000_00B5;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_pend(int r);
    foreach (pend_q[k]) if (pend_q[k].req == r) return k;
    return -1;
  endfunction

  function automatic int find_exp(int r);
    foreach (exp_q[k]) if (exp_q[k].req == r) return k;
    return -1;
  endfunction

  task automatic issue(int r, logic [1:0] c, logic [31:0] a, logic [31:0] d);
    pend_q.push_back('{req: r, cmd: c, addr: a, wdata: d});
    if (cmd_valid(c))
      exp_q.push_back('{req: r, rdata: (c == CMD_READ) ? slv_rdata(a) : 32'h0});
  endtask

  task automatic present();
    for (int r = 0; r < N; r++) begin
      int k;
      k = find_pend(r);
      if (k >= 0) begin
        bus.req_cmd_i[r]   = pend_q[k].cmd;
        bus.req_addr_i[r]  = pend_q[k].addr;
        bus.req_wdata_i[r] = pend_q[k].wdata;
      end else begin
        bus.req_cmd_i[r]   = 2'b00;
        bus.req_addr_i[r]  = '0;
        bus.req_wdata_i[r] = '0;
      end
    end
  endtask

  task automatic slave_update();
    if (bus.psel_o && bus.penable_o) begin
      if (acc_cnt == 0) cur_wait = rand_wait ? int'($urandom_range(9, 0)) : wait_cfg;
      bus.pready_i = (acc_cnt == cur_wait);
      bus.prdata_i = slv_rdata(bus.paddr_o);
      acc_cnt++;
    end else begin
      acc_cnt      = 0;
      bus.pready_i = 1'b0;
      bus.prdata_i = '0;
    end
  endtask

  task automatic drive_now();
    present();
    slave_update();
    #1;
  endtask

  // One clock: monitor at the falling edge, update drivers just after the rising edge.
  task automatic step();
    int rr;
    int k;
    @(negedge clk);
    if (bus.rsp_valid_o != '0) begin
      rsp_cnt++;
      chk("rsp_onehot", 64'($onehot(bus.rsp_valid_o)), 64'd1);
      rr = -1;
      for (int r = 0; r < N; r++) if (bus.rsp_valid_o[r] && rr < 0) rr = r;
      k = find_exp(rr);
      if (k < 0) begin
        chk("rsp_unexpected", 64'(bus.rsp_valid_o), 64'd0);
      end else begin
        chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(exp_q[k].rdata));
        exp_q.delete(k);
      end
    end
    if (bus.req_ready_o[1]) ready1_cnt++;
    if (bus.psel_o) psel_cnt++;
    for (int r = 0; r < N; r++) begin
      acc_s[r] = bus.req_ready_o[r] && cmd_valid(bus.req_cmd_i[r]);
      if (acc_s[r]) begin
        grant_log.push_back(r);
        grant_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < N; r++) begin
      if (acc_s[r]) begin
        k = find_pend(r);
        if (k >= 0) pend_q.delete(k);
      end
    end
    drive_now();
  endtask

  task automatic run_until_drained(string tag, int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pend_q.delete();
    exp_q.delete();
    acc_s = '0;
    drive_now();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drive_now();
  endtask

  initial begin
    int exp_order[5];
    int acc_cycles;
    exp_order = '{0, 1, 2, 3, 0};
    bus.req_cmd_i   = '0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.prdata_i    = '0;
    bus.pready_i    = 1'b0;
    #1;
    chk("rst_ctrl", 64'({bus.psel_o, bus.penable_o, bus.pwrite_o}), 64'd0);
    chk("rst_paddr", 64'(bus.paddr_o), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata_o), 64'd0);
    chk("rst_rsp", 64'({bus.rsp_valid_o, bus.rsp_rdata_o}), 64'd0);
    chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
    do_reset();

    // Single read from requester 2.
    issue(2, CMD_READ, 32'h10, 32'h0);
    drive_now();
    chk("t1_ready", 64'(bus.req_ready_o), 64'b0100);
    chk("t1_idle_psel", 64'(bus.psel_o), 64'd0);
    step();
    chk("t1_setup", 64'({bus.psel_o, bus.penable_o}), 64'b10);
    step();
    chk("t1_access", 64'({bus.psel_o, bus.penable_o}), 64'b11);
    chk("t1_paddr", 64'(bus.paddr_o), 64'h10);
    step();
    chk("t1_rsp_valid", 64'(bus.rsp_valid_o), 64'b0100);
    chk("t1_rsp_rdata", 64'(bus.rsp_rdata_o), 64'hA5);
    step();
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // Four requesters writing back-to-back with zero wait states.
    do_reset();
    grant_log.delete();
    grant_cyc.delete();
    issue(0, CMD_WRITE, 32'h100, 32'h1111_0000);
    issue(1, CMD_WRITE, 32'h104, 32'h2222_0000);
    issue(2, CMD_WRITE, 32'h108, 32'h3333_0000);
    issue(3, CMD_WRITE, 32'h10C, 32'h4444_0000);
    issue(0, CMD_WRITE, 32'h110, 32'h5555_0000);
    drive_now();
    psel_cnt = 0;
    repeat (12) step();
    chk("t2_ngrant", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < grant_log.size() && i < 5; i++) begin
      chk("t2_grant_order", 64'(grant_log[i]), 64'(exp_order[i]));
      if (i > 0) chk("t2_grant_gap", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd2);
    end
    chk("t2_psel_cycles", 64'(psel_cnt), 64'd10);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // Write with three wait states: ACCESS held for four cycles.
    wait_cfg = 3;
    rsp_cnt  = 0;
    acc_cycles = 0;
    issue(1, CMD_WRITE, 32'h20, 32'hDEAD_BEEF);
    drive_now();
    repeat (12) begin
      step();
      if (bus.psel_o && bus.penable_o) begin
        acc_cycles++;
        chk("t3_paddr", 64'(bus.paddr_o), 64'h20);
        chk("t3_pwdata", 64'(bus.pwdata_o), 64'hDEAD_BEEF);
        chk("t3_pwrite", 64'(bus.pwrite_o), 64'd1);
      end
    end
    chk("t3_access_cycles", 64'(acc_cycles), 64'd4);
    chk("t3_rsp_count", 64'(rsp_cnt), 64'd1);
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // Reserved command 11 is never granted.
    wait_cfg   = 0;
    ready1_cnt = 0;
    issue(1, 2'b11, 32'h30, 32'h0);
    issue(3, CMD_WRITE, 32'h40, 32'h1234);
    drive_now();
    chk("t4_ready", 64'(bus.req_ready_o), 64'b1000);
    repeat (8) step();
    chk("t4_reserved_ready", 64'(ready1_cnt), 64'd0);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);
    pend_q.delete();
    drive_now();

    // Reset taken mid-ACCESS, then rr_ptr must restart at 0.
    wait_cfg = 8;
    issue(2, CMD_READ, 32'h50, 32'h0);
    drive_now();
    step();
    step();
    chk("t5_in_access", 64'({bus.psel_o, bus.penable_o}), 64'b11);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_drop", 64'({bus.psel_o, bus.penable_o}), 64'd0);
    chk("t5_paddr_rst", 64'(bus.paddr_o), 64'd0);
    pend_q.delete();
    exp_q.delete();
    acc_s = '0;
    wait_cfg = 0;
    drive_now();
    step();
    issue(0, CMD_READ, 32'h60, 32'h0);
    issue(1, CMD_READ, 32'h61, 32'h0);
    issue(2, CMD_READ, 32'h62, 32'h0);
    issue(3, CMD_READ, 32'h63, 32'h0);
    drive_now();
    chk("t5_ready_in_rst", 64'(bus.req_ready_o), 64'd0);
    step();
    chk("t5_rsp_in_rst", 64'(bus.rsp_valid_o), 64'd0);
    reset = 1'b1;
    #1;
    chk("t5_ptr_restart", 64'(bus.req_ready_o), 64'b0001);
    run_until_drained("t5_drain", 40);

    // Random reads/writes with 1-10 ACCESS cycles per transfer.
    rand_wait = 1'b1;
    rsp_cnt   = 0;
    for (int i = 0; i < 40; i++) begin
      issue(int'($urandom_range(N - 1, 0)),
            ($urandom_range(1, 0) != 0) ? CMD_READ : CMD_WRITE,
            $urandom, $urandom);
    end
    drive_now();
    run_until_drained("t6_drain", 2000);
    chk("t6_rsp_count", 64'(rsp_cnt), 64'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Round-robin arbiter that shares a single APB bus between `NUM_REQ` command requesters and runs the APB master protocol itself. Each requester issues read/write commands with the same 2-bit command encoding the APB master uses. The arbiter serialises them, sequences SETUP/ACCESS, and returns the completion with read data to the requester that issued the command. It sits between the command sources and the APB peripheral fabric, replacing a single-source APB master.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `ADDR_W`, 32: APB address width.
- `DATA_W`, 32: APB data width.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `req_cmd_i`  in  [NUM_REQ][2]  per-requester command: 00 NOP, 01 read, 10 write, 11 reserved and treated as NOP.
- `req_addr_i`  in  [NUM_REQ][ADDR_W]  per-requester address.
- `req_wdata_i`  in  [NUM_REQ][DATA_W]  per-requester write data.
- `req_ready_o`  out  [NUM_REQ]  one-hot accept; a command transfers when its command is non-NOP and its ready bit is 1.
- `rsp_valid_o`  out  [NUM_REQ]  one-hot, one-cycle completion pulse.
- `rsp_rdata_o`  out  DATA_W  read data, qualified by `rsp_valid_o`; 0 for writes.
- `psel_o`, `penable_o`, `pwrite_o`  out  1 each  APB control.
- `paddr_o`  out  ADDR_W  APB address.
- `pwdata_o`  out  DATA_W  APB write data.
- `prdata_i`  in  DATA_W  APB read data.
- `pready_i`  in  1  APB ready.

## Operation
- States: IDLE, SETUP, ACCESS.
- Arbitration window: any IDLE cycle, or an ACCESS cycle with `pready_i`=1.
  - The winner is the first requester with a valid command, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - `req_ready_o[winner]` is driven combinationally in that window. It is 0 outside the window and 0 while reset is asserted.
- On accept:
  - `paddr_o`, `pwrite_o` (1 for write) and `pwdata_o` (write data, 0 for read) are registered.
  - The owner index is stored.
  - `rr_ptr` is set to winner+1, wrapping from `NUM_REQ`-1 to 0.
  - Next state is SETUP.
- The arbitration window with no valid command leads to IDLE. `rr_ptr` is unchanged.
- SETUP: `psel_o`=1, `penable_o`=0. Always advances to ACCESS. `pready_i` is ignored.
- ACCESS: `psel_o`=1, `penable_o`=1. Address, control and write data are held until `pready_i`=1.
- Completion (ACCESS and `pready_i`=1):
  - Next cycle, `rsp_valid_o[owner]`=1 for exactly one cycle.
  - `rsp_rdata_o` = the captured `prdata_i` for reads, 0 for writes.
- Requesters must hold command, address and write data stable until accepted. Dropping a command before acceptance is legal and has no side effects.
- The accepted requester may present its next command on the following cycle. Round-robin ordering guarantees every other valid requester is served first.
- Reset values: state IDLE, `rr_ptr` 0, and every output 0 (`psel_o`, `penable_o`, `pwrite_o`, `paddr_o`, `pwdata_o`, `rsp_valid_o`, `rsp_rdata_o`, `req_ready_o`).
- Reset asserted mid-transfer: APB outputs drop asynchronously, the transfer is abandoned, and no response is issued.

## Timing
- Accept at cycle T, SETUP at T+1, ACCESS at T+2 onward.
- With `pready_i`=1 at T+2, `rsp_valid_o` is high at T+3.
- Back-to-back: the next accept can occur in the completion cycle (T+2). Its SETUP is at T+3, so the bus sustains 2 cycles per transfer with no IDLE between transfers.
- Each wait state (`pready_i`=0 in ACCESS) adds one cycle to both the transfer and the response latency.
- Response pulses never overlap: there is at most one `rsp_valid_o` bit per cycle.

## Structure
- Package `apb_arb_pkg` contains:
  - `typedef enum logic [1:0] apb_state_e` {IDLE, SETUP, ACCESS};
  - `apb_cmd_e` {CMD_NOP=2'b00, CMD_READ=2'b01, CMD_WRITE=2'b10};
  - a `cmd_valid()` function that returns 1 for read and write only.
- Sub-module `rr_pick`: combinational, parameterised by `NUM_REQ`.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant, winner index and `any`.
  - Implemented with a doubled-vector masked priority search.
- The top level holds the FSM, the command and owner registers, and the response register.

## Test plan
- Single read: requester 2 issues cmd 01, addr 0x10, with `pready_i` 1 at the first ACCESS cycle -> `req_ready_o`=0100; `psel_o` at T+1, `penable_o` at T+2; `rsp_valid_o`=0100 at T+3 with `rsp_rdata_o`=`prdata_i` (0xA5).
- All four requesters issue writes continuously with zero wait states -> grants in order 0,1,2,3,0; `psel_o` stays high; 2 cycles per transfer.
- Write to 0x20 with 3 wait states -> `paddr_o`, `pwdata_o` and `penable_o` are stable for 4 ACCESS cycles; the single `rsp_valid_o` pulse has `rsp_rdata_o`=0.
- Requester 1 asserts cmd 11 and requester 3 asserts cmd 10 -> only requester 3 is granted; cmd 11 never gets ready.
- Reset taken low during ACCESS -> `psel_o`=`penable_o`=0 immediately; after release, state IDLE, `rr_ptr`=0, and no stale response.
- Random `pready_i` delays of 1-10 cycles with random reads/writes -> every accepted command gets exactly one response to its issuer, and the checker sees correct read data.
